// File: rtl/player_key_cmd_gen_if.sv
// Keyboard-to-mover command bus for player_key_cmd_gen.
// The slave side (the command generator) receives frame/byte strobes and
// drives the frame-stable move/pause levels; the master side is the reverse.
interface player_key_cmd_gen_if;
    logic       startOfFrame;
    logic       keyValid;
    logic [7:0] keyByte;
    logic       moveLeft;
    logic       moveRight;
    logic       pause;

    modport master (
        output startOfFrame, keyValid, keyByte,
        input  moveLeft, moveRight, pause
    );

    modport slave (
        input  startOfFrame, keyValid, keyByte,
        output moveLeft, moveRight, pause
    );
endinterface

// File: rtl/player_key_cmd_gen.sv
// player_key_cmd_gen: turns PS/2 scan-code bytes into frame-stable,
// active-low moveLeft/moveRight levels plus an active-high pause level.
// Optional feature macro: PLAYER_PAUSE_TOGGLE_EN (pause key toggles pause);
// without it pause is tied low and the pause code is ignored.
module player_key_cmd_gen #(
    parameter logic [7:0] LEFT_CODE      = 8'h6B,
    parameter logic [7:0] RIGHT_CODE     = 8'h74,
    parameter logic [7:0] PAUSE_CODE     = 8'h4D,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    player_key_cmd_gen_if.slave  kb
);
    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXT     = 2'd1;
    localparam logic [1:0] BRK     = 2'd2;
    localparam logic [1:0] EXT_BRK = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int             CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state, stateNext;
    logic [CW-1:0] toCnt;
    logic          evt, evtMake, evtExt;
    logic          leftHeld, rightHeld, lastDir;
    logic          wantLeft, wantRight;

    // Parser next state and make/break event decode for the current byte.
    always_comb begin
        stateNext = state;
        evt       = 1'b0;
        evtMake   = 1'b0;
        evtExt    = 1'b0;
        if (kb.keyValid) begin
            if (kb.keyByte == BYTE_EXT) begin
                // E0 always (re)starts an extended sequence, dropping any break prefix.
                stateNext = EXT;
            end else if (kb.keyByte == BYTE_BRK) begin
                stateNext = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
            end else begin
                stateNext = IDLE;
                evt       = 1'b1;
                evtMake   = (state == IDLE) || (state == EXT);
                evtExt    = (state == EXT)  || (state == EXT_BRK);
            end
        end else if (state != IDLE && toCnt == CNT_MAX) begin
            stateNext = IDLE;
        end
    end

    // Parser state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Prefix timeout counter: runs only while waiting inside a prefix state.
    always_ff @(posedge clk) begin
        if (reset || kb.keyValid || state == IDLE || toCnt == CNT_MAX)
            toCnt <= '0;
        else
            toCnt <= toCnt + CW'(1);
    end

    // Held state of the two direction keys and the most recent direction pressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            leftHeld  <= 1'b0;
            rightHeld <= 1'b0;
            lastDir   <= DIR_LEFT;
        end else if (evt && evtExt) begin
            if (kb.keyByte == LEFT_CODE) begin
                leftHeld <= evtMake;
                if (evtMake) lastDir <= DIR_LEFT;
            end
            if (kb.keyByte == RIGHT_CODE) begin
                rightHeld <= evtMake;
                if (evtMake) lastDir <= DIR_RIGHT;
            end
        end
    end

    // Left+right arbitration: with both held the most recent press wins.
    always_comb begin
        wantLeft  = leftHeld  && (!rightHeld || lastDir == DIR_LEFT);
        wantRight = rightHeld && (!leftHeld  || lastDir == DIR_RIGHT);
    end

    // Move outputs only change at the start of a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            kb.moveLeft  <= 1'b1;
            kb.moveRight <= 1'b1;
        end else if (kb.startOfFrame) begin
            kb.moveLeft  <= ~wantLeft;
            kb.moveRight <= ~wantRight;
        end
    end

`ifdef PLAYER_PAUSE_TOGGLE_EN
    logic pauseReg, pauseSeen;
    logic pauseHit;

    always_comb pauseHit = evt && !evtExt && (kb.keyByte == PAUSE_CODE);

    // Pause toggles once per press; typematic repeats are ignored until a break.
    always_ff @(posedge clk) begin
        if (reset) begin
            pauseReg  <= 1'b0;
            pauseSeen <= 1'b0;
        end else if (pauseHit) begin
            if (evtMake) begin
                if (!pauseSeen) pauseReg <= ~pauseReg;
                pauseSeen <= 1'b1;
            end else begin
                pauseSeen <= 1'b0;
            end
        end
    end

    // Pause level is frame-stable like the move levels.
    always_ff @(posedge clk) begin
        if (reset)                 kb.pause <= 1'b0;
        else if (kb.startOfFrame)  kb.pause <= pauseReg;
    end
`else
    logic unusedPause;
    assign unusedPause = ^PAUSE_CODE;
    assign kb.pause    = 1'b0 & unusedPause;
`endif
endmodule

// File: tb/tb_player_key_cmd_gen.sv
// Bench for player_key_cmd_gen: directed scenarios followed by random bytes,
// each cycle compared against a prefix-flag/held-key reference model.
module tb_player_key_cmd_gen;
    localparam int T = 16;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    player_key_cmd_gen_if kb();

    player_key_cmd_gen #(
        .LEFT_CODE(8'h6B), .RIGHT_CODE(8'h74), .PAUSE_CODE(8'h4D), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .kb(kb.slave)
    );

    always #5 clk = ~clk;

    // reference model state
    bit mExt, mBrk;      // prefixes seen since the last complete code
    int mIdle;           // cycles without a byte since the last byte
    bit mL, mR;          // direction keys currently held
    bit mLastRight;      // most recent direction pressed was right
    bit mP, mSeen;       // pause level and "already toggled in this press"
    bit eL = 1, eR = 1, eP = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit sof, input bit kv, input logic [7:0] b);
        if (rst) begin
            mExt = 0; mBrk = 0; mIdle = 0; mL = 0; mR = 0; mLastRight = 0;
            mP = 0; mSeen = 0; eL = 1; eR = 1; eP = 0;
            return;
        end
        if (sof) begin
            eL = 1; eR = 1;
            if (mL && mR) begin
                if (mLastRight) eR = 0; else eL = 0;
            end else if (mL) eL = 0;
            else if (mR) eR = 0;
`ifdef PLAYER_PAUSE_TOGGLE_EN
            eP = mP;
`endif
        end
        if (kv) begin
            if (mIdle >= T) begin mExt = 0; mBrk = 0; end
            mIdle = 0;
            if (b == 8'hE0) begin
                mExt = 1; mBrk = 0;
            end else if (b == 8'hF0) begin
                mBrk = 1;
            end else begin
                if (mExt && b == 8'h6B) begin mL = !mBrk; if (!mBrk) mLastRight = 0; end
                if (mExt && b == 8'h74) begin mR = !mBrk; if (!mBrk) mLastRight = 1; end
`ifdef PLAYER_PAUSE_TOGGLE_EN
                if (!mExt && b == 8'h4D) begin
                    if (!mBrk) begin
                        if (!mSeen) mP = !mP;
                        mSeen = 1;
                    end else mSeen = 0;
                end
`endif
                mExt = 0; mBrk = 0;
            end
        end else if (mIdle < 1000) mIdle++;
    endtask

    task automatic cyc(input bit rst, input bit sof, input bit kv, input logic [7:0] b);
        reset = rst; kb.startOfFrame = sof; kb.keyValid = kv; kb.keyByte = b;
        @(posedge clk);
        model_step(rst, sof, kv, b);
        #1;
        check("moveLeft",  kb.moveLeft,  eL);
        check("moveRight", kb.moveRight, eR);
        check("pause",     kb.pause,     eP);
        check("exclusive", kb.moveLeft | kb.moveRight, 1'b1);
    endtask

    task automatic send(input logic [7:0] b); cyc(0, 0, 1, b); endtask
    task automatic frame();                    cyc(0, 1, 0, 8'h00); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00);
    endtask

    task automatic expect_out(input string tag, input logic l, input logic r);
        check({tag, "_L"}, kb.moveLeft, l);
        check({tag, "_R"}, kb.moveRight, r);
    endtask

    logic [7:0] pool [0:6];

    initial begin
        pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h6B; pool[3] = 8'h74;
        pool[4] = 8'h4D; pool[5] = 8'h1C; pool[6] = 8'h6B;

        // 1: reset held while random traffic arrives
        for (int i = 0; i < 24; i++)
            cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 6)]);
        expect_out("t1", 1'b1, 1'b1);
        check("t1_pause", kb.pause, 1'b0);
        idle(2);

        // 2: extended left make then break
        send(8'hE0); send(8'h6B); idle(1); frame();
        expect_out("t2_make", 1'b0, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h6B); frame();
        expect_out("t2_break", 1'b1, 1'b1);

        // 3: both held -> last pressed wins; release it -> the other one
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74); frame();
        expect_out("t3_both", 1'b1, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h74); frame();
        expect_out("t3_left", 1'b0, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h6B); frame();
        expect_out("t3_none", 1'b1, 1'b1);

        // 4: final byte on the start-of-frame cycle is deferred a frame
        send(8'hE0); cyc(0, 1, 1, 8'h74);
        expect_out("t4_same", 1'b1, 1'b1);
        idle(3); frame();
        expect_out("t4_next", 1'b1, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h74); frame();
        expect_out("t4_rel", 1'b1, 1'b1);

        // 5: prefix timeout boundary
        send(8'hE0); idle(T); send(8'h6B); frame();
        expect_out("t5_timeout", 1'b1, 1'b1);
        send(8'hE0); idle(T - 1); send(8'h6B); frame();
        expect_out("t5_in_time", 1'b0, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h6B); frame();
        expect_out("t5_rel", 1'b1, 1'b1);

        // reset mid-sequence discards the prefix
        send(8'hE0); cyc(1, 0, 0, 8'h00); send(8'h6B); frame();
        expect_out("rst_mid", 1'b1, 1'b1);

        // 6: pause toggle with typematic repeats
        send(8'h4D); frame();
`ifdef PLAYER_PAUSE_TOGGLE_EN
        check("t6_p1", kb.pause, 1'b1);
`else
        check("t6_p1", kb.pause, 1'b0);
`endif
        send(8'h4D); frame();
`ifdef PLAYER_PAUSE_TOGGLE_EN
        check("t6_p2", kb.pause, 1'b1);
`else
        check("t6_p2", kb.pause, 1'b0);
`endif
        send(8'hF0); send(8'h4D); frame();
        send(8'h4D); frame();
        check("t6_p3", kb.pause, 1'b0);
        send(8'h4D); frame();
        check("t6_p4", kb.pause, 1'b0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0)
                cyc(1, 0, 0, 8'h00);
            else if ($urandom_range(0, 59) == 0)
                idle($urandom_range(T - 2, T + 4));
            else
                cyc(0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                    pool[$urandom_range(0, 6)]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
